// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared constants and owner encoding for the data-memory arbiter
package dmem_pkg;
  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_DW = 32;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes for both ports plus the memory-side bus
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          p0_valid, p0_write, p0_ready, p0_rvalid, p0_err;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_valid, p1_write, p1_ready, p1_rvalid, p1_err;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  p0_valid, p0_write, p0_addr, p0_wdata,
    input  p1_valid, p1_write, p1_addr, p1_wdata, mem_rdata,
    output p0_ready, p0_rvalid, p0_rdata, p0_err,
    output p1_ready, p1_rvalid, p1_rdata, p1_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output p0_valid, p0_write, p0_addr, p0_wdata,
    output p1_valid, p1_write, p1_addr, p1_wdata, mem_rdata,
    input  p0_ready, p0_rvalid, p0_rdata, p0_err,
    input  p1_ready, p1_rvalid, p1_rdata, p1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_grant.sv
// dmem_rr_grant: bounded-burst round-robin grant between two requesters
module dmem_rr_grant
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  owner_t owner_q, owner_d;
  logic rr_last_q, rr_last_d;
  logic [CW-1:0] beat_q, beat_d;
  logic stay0, stay1;
  // Grant is one-hot; an owner keeps the port until its burst budget runs out while the other waits.
  always_comb begin
    stay0 = owner_q == OWN_P0 && valid_i[0] && (beat_q < CW'(MAX_BURST) || !valid_i[1]);
    stay1 = owner_q == OWN_P1 && valid_i[1] && (beat_q < CW'(MAX_BURST) || !valid_i[0]);
    grant_o = reset ? 2'b00 : stay0 ? 2'b01 : stay1 ? 2'b10 :
              valid_i == 2'b11 ? (rr_last_q ? 2'b01 : 2'b10) : valid_i;
    owner_d = grant_o[0] ? OWN_P0 : grant_o[1] ? OWN_P1 : OWN_NONE;
    beat_d = grant_o == 2'b00 ? '0 : owner_d != owner_q ? CW'(1) :
             beat_q == CW'(MAX_BURST) ? beat_q : beat_q + CW'(1);
    rr_last_d = grant_o == 2'b00 ? rr_last_q : grant_o[1];
  end
  // Ownership state; rr_last resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      rr_last_q <= 1'b1;
      beat_q <= '0;
    end else begin
      owner_q <= owner_d;
      rr_last_q <= rr_last_d;
      beat_q <= beat_d;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int DW = DMEM_DW,
  parameter int AW = 32,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  logic [1:0] grant;
  logic acc, sel, wr, in_range, rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rd;
  logic [1:0] rvalid_q, rvalid_d, err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  dmem_rr_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk(clk),
    .reset(reset),
    .valid_i({bus.p1_valid, bus.p0_valid}),
    .grant_o(grant)
  );

  assign bus.p0_ready = grant[0];
  assign bus.p1_ready = grant[1];
  assign bus.mem_read = rd_en;
  assign bus.mem_write = wr_en;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.p0_err = err_q[0];
  assign bus.p1_err = err_q[1];
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;

  // Steer the granted request to memory; the full address is range-checked so high bits never alias.
  always_comb begin
    acc = |grant;
    sel = grant[1];
    wr = sel ? bus.p1_write : bus.p0_write;
    addr = acc ? (sel ? bus.p1_addr : bus.p0_addr) : '0;
    wdata = acc ? (sel ? bus.p1_wdata : bus.p0_wdata) : '0;
    in_range = addr < AW'(DEPTH);
    rd_en = acc && in_range && !wr;
    wr_en = acc && in_range && wr;
    rd = rd_en ? bus.mem_rdata : '0;
    rvalid_d = grant;
    err_d = grant & {2{!in_range}};
    rdata0_d = grant[0] ? rd : '0;
    rdata1_d = grant[1] ? rd : '0;
  end

  // One-cycle response registers; reset drops any response still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
      err_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int AW = 40;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter_if #(.AW(AW), .DW(32)) bus ();
  dmem_arbiter #(.AW(AW), .DW(32), .MAX_BURST(MAXB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // Memory under arbitration: combinational read, write on posedge, contents i*20 on reset.
  logic [31:0] mem [32];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i * 20);
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];

  // Reference model state.
  logic [31:0] ref_mem [32];
  int m_owner, m_last, m_cnt;
  int acc_obs [2];
  int rv_obs [2];

  task automatic model_reset();
    m_owner = -1;
    m_last = 1;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i * 20);
  endtask

  function automatic int pick(input logic v0, input logic v1);
    if (m_owner == 0 && v0 && (m_cnt < MAXB || !v1)) return 0;
    if (m_owner == 1 && v1 && (m_cnt < MAXB || !v0)) return 1;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check request side #1 later, check responses at the next negedge.
  task automatic cycle(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1);
    int g;
    logic w, inr;
    logic [AW-1:0] a;
    logic [31:0] d, e_rd;
    bus.p0_valid = v0; bus.p0_write = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_valid = v1; bus.p1_write = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    #1;
    g = pick(v0, v1);
    chk("p0_ready", {63'b0, bus.p0_ready}, {63'b0, g == 0});
    chk("p1_ready", {63'b0, bus.p1_ready}, {63'b0, g == 1});
    if (v0 && bus.p0_ready) acc_obs[0]++;
    if (v1 && bus.p1_ready) acc_obs[1]++;
    w = (g == 1) ? w1 : w0;
    a = (g == 1) ? a1 : a0;
    d = (g == 1) ? d1 : d0;
    inr = a < AW'(32);
    chk("mem_read", {63'b0, bus.mem_read}, {63'b0, g >= 0 && inr && !w});
    chk("mem_write", {63'b0, bus.mem_write}, {63'b0, g >= 0 && inr && w});
    if (g < 0 || inr) begin
      chk("mem_addr", 64'(bus.mem_addr), g < 0 ? 64'd0 : 64'(a));
      chk("mem_wdata", 64'(bus.mem_wdata), g < 0 ? 64'd0 : 64'(d));
    end
    e_rd = 32'd0;
    if (g >= 0 && inr && w) ref_mem[a[4:0]] = d;
    if (g >= 0 && inr && !w) e_rd = ref_mem[a[4:0]];
    if (g >= 0) begin
      m_cnt = (m_owner == g) ? ((m_cnt < MAXB) ? m_cnt + 1 : MAXB) : 1;
      m_owner = g;
      m_last = g;
    end else begin
      m_owner = -1;
      m_cnt = 0;
    end
    @(negedge clk);
    rv_obs[0] += int'(bus.p0_rvalid);
    rv_obs[1] += int'(bus.p1_rvalid);
    chk("p0_rvalid", {63'b0, bus.p0_rvalid}, {63'b0, g == 0});
    chk("p1_rvalid", {63'b0, bus.p1_rvalid}, {63'b0, g == 1});
    if (g == 0) begin
      chk("p0_rdata", 64'(bus.p0_rdata), 64'(e_rd));
      chk("p0_err", {63'b0, bus.p0_err}, {63'b0, !inr});
    end
    if (g == 1) begin
      chk("p1_rdata", 64'(bus.p1_rdata), 64'(e_rd));
      chk("p1_err", {63'b0, bus.p1_err}, {63'b0, !inr});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy0"}, {63'b0, bus.p0_ready}, 64'd0);
    chk({tag, "_rdy1"}, {63'b0, bus.p1_ready}, 64'd0);
    chk({tag, "_mrd"}, {63'b0, bus.mem_read}, 64'd0);
    chk({tag, "_mwr"}, {63'b0, bus.mem_write}, 64'd0);
    chk({tag, "_rv0"}, {63'b0, bus.p0_rvalid}, 64'd0);
    chk({tag, "_rv1"}, {63'b0, bus.p1_rvalid}, 64'd0);
    chk({tag, "_rd0"}, 64'(bus.p0_rdata), 64'd0);
    chk({tag, "_rd1"}, 64'(bus.p1_rdata), 64'd0);
    chk({tag, "_err"}, {62'b0, bus.p1_err, bus.p0_err}, 64'd0);
  endtask

  initial begin
    logic v0, v1, w0, w1;
    logic [AW-1:0] a0, a1;
    bus.p0_valid = 0; bus.p0_write = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_valid = 0; bus.p1_write = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    acc_obs[0] = 0; acc_obs[1] = 0; rv_obs[0] = 0; rv_obs[1] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    bus.p0_valid = 1;
    #1 chk_all_zero("in_reset");
    bus.p0_valid = 0;
    @(negedge clk);
    reset = 0;

    // Load right after reset release returns the initial contents.
    cycle(1, 0, 3, 0, 0, 0, 0, 0);
    chk("ld3_value", 64'(bus.p0_rdata), 64'd60);
    // Store then immediate load of the same address.
    cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cycle(1, 0, 5, 0, 0, 0, 0, 0);
    chk("st_ld_value", 64'(bus.p0_rdata), 64'hDEADBEEF);
    // Out-of-range loads, including nonzero upper address bits.
    cycle(1, 0, 32, 0, 0, 0, 0, 0);
    chk("oor32_err", {63'b0, bus.p0_err}, 64'd1);
    cycle(1, 0, AW'(64'h100000001), 0, 0, 0, 0, 0);
    chk("oor_hi_err", {63'b0, bus.p0_err}, 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Both ports contend continuously.
    for (int i = 0; i < 12; i++) cycle(1, 0, AW'(i), 0, 1, 0, AW'(i + 8), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Port 1 alone for 10 cycles, then port 0 joins.
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1, AW'(i + 20), 32'(i));
    for (int i = 0; i < 3; i++) cycle(1, 0, AW'(i + 20), 0, 1, 0, AW'(i), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset lands between a port-1 accept and its response.
    bus.p1_valid = 1; bus.p1_write = 0; bus.p1_addr = 7;
    #1 chk("pre_rst_rdy1", {63'b0, bus.p1_ready}, 64'd1);
    @(posedge clk);
    #1 reset = 1;
    bus.p0_valid = 1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    chk_all_zero("hold_reset");
    bus.p0_valid = 0; bus.p1_valid = 0;
    reset = 0;
    model_reset();
    #1 chk("post_rst_rv1", {63'b0, bus.p1_rvalid}, 64'd0);
    @(negedge clk);
    cycle(1, 0, 2, 0, 1, 0, 4, 0);
    chk("tie_after_rst", {63'b0, bus.p0_rvalid}, 64'd1);

    // Randomised traffic, valids biased towards contention.
    for (int i = 0; i < 400; i++) begin
      v0 = $urandom_range(0, 3) != 0;
      v1 = $urandom_range(0, 3) != 0;
      w0 = $urandom_range(0, 1) == 1;
      w1 = $urandom_range(0, 1) == 1;
      a0 = ($urandom_range(0, 9) == 0) ? AW'({$urandom, $urandom}) : AW'($urandom_range(0, 40));
      a1 = ($urandom_range(0, 9) == 0) ? AW'({$urandom, $urandom}) : AW'($urandom_range(0, 40));
      cycle(v0, w0, a0, $urandom, v1, w1, a1, $urandom);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rv_count0", 64'(rv_obs[0]), 64'(acc_obs[0]));
    chk("rv_count1", 64'(rv_obs[1]), 64'(acc_obs[1]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
